// File: rtl/mkt_pkg.sv
// Shared types and constants for the market-data parsing path.
package mkt_pkg;

  localparam logic [7:0]  ADD_TYPE_DEFAULT = 8'h41;
  localparam int unsigned ADD_MIN_LEN      = 5;

  localparam int unsigned HDR_TYPE_MSB = 15;
  localparam int unsigned HDR_TYPE_LSB = 8;
  localparam int unsigned HDR_LEN_MSB  = 7;
  localparam int unsigned HDR_LEN_LSB  = 0;

  localparam int unsigned LEN_W = 8;
  localparam int unsigned IDX_W = 3;

  typedef struct packed {
    logic [31:0] id;
    logic [31:0] price;
    logic [14:0] qty;
    logic        side;
  } add_order_t;

  typedef enum logic [1:0] {
    HDR,
    FIELD,
    SKIP
  } parse_state_t;

endpackage

// File: rtl/avst_out_reg.sv
// One-entry registered record slot with valid/ready handshake; a load wins over a consume.
module avst_out_reg
  import mkt_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  add_order_t rec_next,
  input  logic       ready,
  output logic       valid,
  output add_order_t rec
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      rec   <= '0;
    end else if (load) begin
      valid <= 1'b1;
      rec   <= rec_next;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/itch_add_order_parser.sv
// Frames a 16-bit length-prefixed message stream and extracts add-order records.
module itch_add_order_parser
  import mkt_pkg::*;
#(
  parameter logic [7:0]  ADD_TYPE = ADD_TYPE_DEFAULT,
  parameter int unsigned MIN_LEN  = ADD_MIN_LEN,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk_hifreq,
  input  logic             rst,
  input  logic [15:0]      data_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic             ord_valid,
  input  logic             ord_ready,
  output logic [31:0]      ord_id,
  output logic [31:0]      ord_price,
  output logic [14:0]      ord_qty,
  output logic             ord_side,
  output logic [CNT_W-1:0] msg_count,
  output logic [CNT_W-1:0] drop_count
);

  parse_state_t     state;
  logic [LEN_W-1:0] remaining;
  logic [IDX_W-1:0] idx;
  logic [31:0]      id_sh;
  logic [31:0]      price_sh;
  logic             xfer;
  logic             load;
  logic             is_add;
  logic [7:0]       hdr_type;
  logic [LEN_W-1:0] hdr_len;
  add_order_t       rec_next;
  add_order_t       rec;

  // Stall only while a finished record is waiting on downstream.
  assign ready_out = !(ord_valid && !ord_ready);
  assign xfer      = valid_in && ready_out;
  assign hdr_type  = data_in[HDR_TYPE_MSB:HDR_TYPE_LSB];
  assign hdr_len   = data_in[HDR_LEN_MSB:HDR_LEN_LSB];
  assign is_add    = (hdr_type == ADD_TYPE);
  assign load      = xfer && (state == FIELD) && (idx == IDX_W'(5));
  assign rec_next  = '{id: id_sh, price: price_sh, qty: data_in[14:0], side: data_in[15]};

  always_ff @(posedge clk_hifreq or negedge rst) begin
    if (!rst) begin
      state      <= HDR;
      remaining  <= '0;
      idx        <= '0;
      id_sh      <= '0;
      price_sh   <= '0;
      msg_count  <= '0;
      drop_count <= '0;
    end else if (xfer) begin
      case (state)
        HDR: begin
          remaining <= hdr_len;
          if (hdr_len == '0) begin
            if (is_add) drop_count <= drop_count + CNT_W'(1);
            state <= HDR;
          end else if (is_add && (32'(hdr_len) < MIN_LEN)) begin
            drop_count <= drop_count + CNT_W'(1);
            state      <= SKIP;
          end else if (is_add) begin
            idx   <= IDX_W'(1);
            state <= FIELD;
          end else begin
            state <= SKIP;
          end
        end
        FIELD: begin
          remaining <= remaining - LEN_W'(1);
          case (idx)
            IDX_W'(1): id_sh[31:16]    <= data_in;
            IDX_W'(2): id_sh[15:0]     <= data_in;
            IDX_W'(3): price_sh[31:16] <= data_in;
            IDX_W'(4): price_sh[15:0]  <= data_in;
            default: ;
          endcase
          if (idx == IDX_W'(5)) begin
            idx       <= '0;
            msg_count <= msg_count + CNT_W'(1);
            state     <= (remaining == LEN_W'(1)) ? HDR : SKIP;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        SKIP: begin
          remaining <= remaining - LEN_W'(1);
          if (remaining == LEN_W'(1)) state <= HDR;
        end
        default: state <= HDR;
      endcase
    end
  end

  avst_out_reg u_out (
    .clk      (clk_hifreq),
    .rst_n    (rst),
    .load     (load),
    .rec_next (rec_next),
    .ready    (ord_ready),
    .valid    (ord_valid),
    .rec      (rec)
  );

  assign ord_id    = rec.id;
  assign ord_price = rec.price;
  assign ord_qty   = rec.qty;
  assign ord_side  = rec.side;

endmodule

// File: tb/tb_itch_add_order_parser.sv
// Directed bench for itch_add_order_parser: framing, skips, drops, backpressure, reset.
module tb_itch_add_order_parser;

  typedef struct packed {
    logic [31:0] id;
    logic [31:0] price;
    logic        side;
    logic [14:0] qty;
  } rec_t;

  logic        clk_hifreq = 1'b0;
  logic        rst        = 1'b0;
  logic [15:0] data_in    = '0;
  logic        valid_in   = 1'b0;
  logic        ready_out;
  logic        ord_valid;
  logic        ord_ready  = 1'b1;
  logic [31:0] ord_id;
  logic [31:0] ord_price;
  logic [14:0] ord_qty;
  logic        ord_side;
  logic [31:0] msg_count;
  logic [31:0] drop_count;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   gap_max  = 0;
  int   exp_msg  = 0;
  int   exp_drop = 0;
  rec_t got[$];
  rec_t exp[$];

  itch_add_order_parser dut (
    .clk_hifreq (clk_hifreq),
    .rst        (rst),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .ready_out  (ready_out),
    .ord_valid  (ord_valid),
    .ord_ready  (ord_ready),
    .ord_id     (ord_id),
    .ord_price  (ord_price),
    .ord_qty    (ord_qty),
    .ord_side   (ord_side),
    .msg_count  (msg_count),
    .drop_count (drop_count)
  );

  always #5 clk_hifreq = ~clk_hifreq;

  // Record every completed output handshake.
  always @(posedge clk_hifreq)
    if (rst && ord_valid && ord_ready) got.push_back(rec_t'({ord_id, ord_price, ord_side, ord_qty}));

  task automatic idle(input int n);
    valid_in = 1'b0;
    repeat (n) @(posedge clk_hifreq);
    #1;
  endtask

  task automatic send(input logic [15:0] w);
    int n;
    int gaps;
    gaps = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
    if (gaps > 0) idle(gaps);
    data_in  = w;
    valid_in = 1'b1;
    n = 0;
    do begin
      @(posedge clk_hifreq);
      n++;
    end while (!ready_out && n < 50);
    if (!ready_out) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: word %h never accepted", w);
    end
    #1;
    valid_in = 1'b0;
  endtask

  task automatic send_add(input logic [31:0] id, input logic [31:0] price,
                          input logic side, input logic [14:0] qty, input int len);
    send({8'h41, 8'(len)});
    send(id[31:16]);
    send(id[15:0]);
    send(price[31:16]);
    send(price[15:0]);
    send({side, qty});
    for (int i = 5; i < len; i++) send(16'hA5A0 ^ 16'(i));
    exp.push_back({id, price, side, qty});
    exp_msg++;
  endtask

  task automatic test_reset();
    #1;
    n_checks++; if (ord_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b exp 0", ord_valid); end
    n_checks++; if (ord_id !== 32'h0) begin n_fail++; $display("FAIL reset_id: got %h exp 0", ord_id); end
    n_checks++; if (ord_price !== 32'h0 || ord_qty !== 15'h0 || ord_side !== 1'b0) begin
      n_fail++; $display("FAIL reset_fields: price %h qty %h side %b exp 0", ord_price, ord_qty, ord_side); end
    n_checks++; if (msg_count !== 32'h0 || drop_count !== 32'h0) begin
      n_fail++; $display("FAIL reset_counts: msg %0d drop %0d exp 0", msg_count, drop_count); end
    n_checks++; if (ready_out !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b exp 1", ready_out); end
    @(negedge clk_hifreq);
    rst = 1'b1;
    idle(2);
  endtask

  task automatic test_single_add();
    got.delete(); exp.delete();
    ord_ready = 1'b1;
    send(16'h4105); send(16'h1234); send(16'h5678);
    send(16'h0001); send(16'h86A0); send(16'h8064);
    exp.push_back({32'h12345678, 32'h000186A0, 1'b1, 15'h0064});
    exp_msg = 1;
    n_checks++; if (ord_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b exp 1", ord_valid); end
    n_checks++; if (ord_id !== 32'h12345678) begin n_fail++; $display("FAIL single_id: got %h exp 12345678", ord_id); end
    n_checks++; if (ord_price !== 32'h000186A0) begin n_fail++; $display("FAIL single_price: got %h exp 000186a0", ord_price); end
    n_checks++; if (ord_side !== 1'b1) begin n_fail++; $display("FAIL single_side: got %b exp 1", ord_side); end
    n_checks++; if (ord_qty !== 15'h0064) begin n_fail++; $display("FAIL single_qty: got %h exp 0064", ord_qty); end
    n_checks++; if (msg_count !== 32'd1) begin n_fail++; $display("FAIL single_msg: got %0d exp 1", msg_count); end
    idle(2);
    n_checks++; if (ord_valid !== 1'b0) begin n_fail++; $display("FAIL single_clear: got %b exp 0", ord_valid); end
    n_checks++; if (got.size() != 1 || got[0] !== exp[0]) begin
      n_fail++; $display("FAIL single_handshake: got %0d records exp 1", got.size()); end
  endtask

  task automatic test_skip_non_add();
    got.delete(); exp.delete();
    send(16'h4503); send(16'h4105); send(16'h1111); send(16'h2222);
    send_add(32'hCAFEBABE, 32'h00ABCDEF, 1'b0, 15'h1234, 5);
    idle(3);
    n_checks++; if (got.size() != exp.size()) begin
      n_fail++; $display("FAIL skip_count: got %0d records exp %0d", got.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      n_checks++; if (got[i] !== exp[i]) begin n_fail++; $display("FAIL skip_rec%0d: got %h exp %h", i, got[i], exp[i]); end
    end
    n_checks++; if (msg_count !== 32'(exp_msg) || drop_count !== 32'(exp_drop)) begin
      n_fail++; $display("FAIL skip_counters: msg %0d drop %0d exp %0d %0d", msg_count, drop_count, exp_msg, exp_drop); end
  endtask

  task automatic test_short_add();
    got.delete(); exp.delete();
    send(16'h4102); send(16'h4105); send(16'h0000);
    exp_drop++;
    send(16'h4100);
    exp_drop++;
    send_add(32'h0BADF00D, 32'h7FFFFFFF, 1'b1, 15'h7FFF, 5);
    idle(3);
    n_checks++; if (drop_count !== 32'(exp_drop)) begin
      n_fail++; $display("FAIL short_drop: got %0d exp %0d", drop_count, exp_drop); end
    n_checks++; if (got.size() != exp.size()) begin
      n_fail++; $display("FAIL short_count: got %0d records exp %0d", got.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      n_checks++; if (got[i] !== exp[i]) begin n_fail++; $display("FAIL short_rec%0d: got %h exp %h", i, got[i], exp[i]); end
    end
    n_checks++; if (msg_count !== 32'(exp_msg)) begin
      n_fail++; $display("FAIL short_msg: got %0d exp %0d", msg_count, exp_msg); end
  endtask

  task automatic test_back_to_back();
    got.delete(); exp.delete();
    ord_ready = 1'b0;
    fork
      begin : producer
        send_add(32'hA1A2A3A4, 32'h00001000, 1'b0, 15'h0010, 5);
        send_add(32'hB1B2B3B4, 32'h00002000, 1'b1, 15'h0020, 5);
      end
      begin : consumer
        int n;
        n = 0;
        while (!ord_valid && n < 100) begin @(negedge clk_hifreq); n++; end
        n_checks++; if (ord_valid !== 1'b1) begin n_fail++; $display("FAIL bp_first_valid: got %b exp 1", ord_valid); end
        repeat (4) begin
          @(negedge clk_hifreq);
          n_checks++; if (ready_out !== 1'b0) begin n_fail++; $display("FAIL bp_ready: got %b exp 0", ready_out); end
          n_checks++; if (ord_id !== 32'hA1A2A3A4 || ord_price !== 32'h00001000) begin
            n_fail++; $display("FAIL bp_stable: id %h price %h exp a1a2a3a4 00001000", ord_id, ord_price); end
        end
        ord_ready = 1'b1;
      end
    join
    idle(3);
    n_checks++; if (got.size() != 2) begin n_fail++; $display("FAIL bp_count: got %0d records exp 2", got.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      n_checks++; if (got[i] !== exp[i]) begin n_fail++; $display("FAIL bp_rec%0d: got %h exp %h", i, got[i], exp[i]); end
    end
    n_checks++; if (msg_count !== 32'(exp_msg)) begin n_fail++; $display("FAIL bp_msg: got %0d exp %0d", msg_count, exp_msg); end
  endtask

  task automatic test_oversize_gaps();
    got.delete(); exp.delete();
    gap_max = 2;
    send_add(32'h01020304, 32'h05060708, 1'b1, 15'h0155, 8);
    send_add(32'hDEADBEEF, 32'h00000001, 1'b0, 15'h2AAA, 5);
    gap_max = 0;
    idle(3);
    n_checks++; if (got.size() != exp.size()) begin
      n_fail++; $display("FAIL over_count: got %0d records exp %0d", got.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      n_checks++; if (got[i] !== exp[i]) begin n_fail++; $display("FAIL over_rec%0d: got %h exp %h", i, got[i], exp[i]); end
    end
    n_checks++; if (msg_count !== 32'(exp_msg) || drop_count !== 32'(exp_drop)) begin
      n_fail++; $display("FAIL over_counters: msg %0d drop %0d exp %0d %0d", msg_count, drop_count, exp_msg, exp_drop); end
  endtask

  task automatic test_midframe_reset();
    got.delete(); exp.delete();
    send(16'h4105); send(16'h9999); send(16'h8888); send(16'h7777);
    #2 rst = 1'b0;
    #1;
    n_checks++; if (ord_valid !== 1'b0 || ord_id !== 32'h0 || ord_price !== 32'h0 || ord_qty !== 15'h0) begin
      n_fail++; $display("FAIL mid_rst_outputs: valid %b id %h price %h qty %h exp 0", ord_valid, ord_id, ord_price, ord_qty); end
    n_checks++; if (msg_count !== 32'h0 || drop_count !== 32'h0) begin
      n_fail++; $display("FAIL mid_rst_counts: msg %0d drop %0d exp 0", msg_count, drop_count); end
    exp_msg = 0;
    exp_drop = 0;
    repeat (2) @(negedge clk_hifreq);
    rst = 1'b1;
    idle(1);
    send_add(32'h13572468, 32'h0000FFFF, 1'b0, 15'h0001, 5);
    idle(3);
    n_checks++; if (got.size() != 1) begin n_fail++; $display("FAIL mid_count: got %0d records exp 1", got.size()); end
    n_checks++; if (got.size() > 0 && got[0] !== exp[0]) begin
      n_fail++; $display("FAIL mid_rec: got %h exp %h", got[0], exp[0]); end
    n_checks++; if (msg_count !== 32'd1 || drop_count !== 32'd0) begin
      n_fail++; $display("FAIL mid_counters: msg %0d drop %0d exp 1 0", msg_count, drop_count); end
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_skip_non_add();
    test_short_add();
    test_back_to_back();
    test_oversize_gaps();
    test_midframe_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/itch_add_order_parser.md
Name: itch_add_order_parser

Overview:
- Downstream stage of the Ethernet test source; consumes its 16-bit Avalon-ST word stream.
- Frames the stream into length-prefixed market-data messages and extracts add-order records (id, price, qty, side) onto a registered record interface.
- Non-add messages are skipped. Malformed add messages are dropped and counted.
- Output feeds the order-book stage.

Parameters:
- ADD_TYPE, 8'h41, message type code for an add-order message.
- MIN_LEN, 5, minimum payload words required for an add-order message.
- CNT_W, 32, width of the statistics counters.

Ports:
- clk_hifreq  in  1  sole clock; all logic is rising-edge.
- rst  in  1  asynchronous, active-low reset.
- data_in  in  16  Avalon-ST word from upstream.
- valid_in  in  1  data_in is valid.
- ready_out  out  1  parser accepts a word this cycle.
- ord_valid  out  1  extracted record is valid.
- ord_ready  in  1  downstream accepts the record.
- ord_id  out  32  order id.
- ord_price  out  32  price, fixed-point, unsigned.
- ord_qty  out  15  quantity.
- ord_side  out  1  1 = sell, 0 = buy.
- msg_count  out  CNT_W  count of add-order records emitted.
- drop_count  out  CNT_W  count of add-order messages dropped because len < MIN_LEN.

Behaviour:
- Transfer rule: a word transfers when valid_in && ready_out.
- ready_out = !(ord_valid && !ord_ready). The parser stalls only while a record is held unconsumed. This is combinational from registered ord_valid and the ord_ready input.
- Frame format:
  - Header word = {type[15:8], len[7:0]}; len is the number of payload words that follow (0..255).
  - Add-order payload: w1 = id[31:16], w2 = id[15:0], w3 = price[31:16], w4 = price[15:0], w5 = {side, qty[14:0]}.
  - Payload words beyond w5 are discarded.
- FSM states: HDR, FIELD, SKIP. Reset state is HDR.
  - HDR, header transferred:
    - len == 0: stay in HDR. If type == ADD_TYPE, also count a drop.
    - type == ADD_TYPE and len < MIN_LEN: drop_count++, remaining = len, go to SKIP.
    - type == ADD_TYPE and len >= MIN_LEN: idx = 1, remaining = len, go to FIELD.
    - otherwise: remaining = len, go to SKIP.
  - FIELD: each transfer writes the indexed field into a shadow register and decrements remaining.
    - On w5: load the output registers from the shadow plus w5, set ord_valid = 1, msg_count++.
    - Then go to HDR if remaining reaches 0, else to SKIP.
  - SKIP: each transfer decrements remaining; go to HDR when it reaches 0.
- Output timing:
  - Latency is 1 cycle: ord_* are valid in the cycle after w5 transfers.
  - ord_valid clears on ord_valid && ord_ready, unless a new w5 transfers in the same cycle. In that case ord_valid stays 1 and the fields take the new record.
  - Simultaneous consume and new load is legal because ready_out is 1 whenever ord_ready is 1.
  - Output fields hold stable while ord_valid && !ord_ready.
- Counters: wrap modulo 2^CNT_W with no saturation. drop_count and msg_count never increment in the same cycle.
- Reset (async assert, sync release) forces the following, aborting any frame mid-parse with no partial record emitted:
  - state = HDR
  - ord_valid = 0; ord_id, ord_price, ord_qty, ord_side = 0
  - msg_count = 0, drop_count = 0
  - remaining = 0, idx = 0
- Idle cycles: valid_in low, including mid-frame, holds all state.
- Framing: there is no resynchronisation marker; the parser trusts len.

Decomposition:
- Package mkt_pkg:
  - typedef add_order_t (packed: id, price, qty, side)
  - typedef parse_state_t {HDR, FIELD, SKIP}
  - constants ADD_TYPE_DEFAULT, ADD_MIN_LEN, HDR_TYPE_MSB/LSB, HDR_LEN_MSB/LSB
- Sub-module avst_out_reg: one-entry registered output holding add_order_t with valid/ready. Instantiated once.

Test Plan:
- Single add: hdr 16'h4105, words 1234, 5678, 0001, 86A0, 8064 with ready held 1 -> one cycle after last word: ord_valid=1, ord_id=32'h12345678, ord_price=32'h000186A0, ord_side=1, ord_qty=15'h0064, msg_count=1.
- Skip non-add: hdr 16'h4503 plus 3 words, then a valid add frame -> only the add record appears; msg_count=1, drop_count=0.
- Short add: hdr 16'h4102 plus 2 words, then a valid add -> drop_count=1, next record correct, no spurious ord_valid.
- Backpressure: ord_ready=0 after the first record, two back-to-back add frames -> ready_out drops while the record is held, fields stable. Raise ord_ready -> both records are delivered in order with no loss.
- Oversize add and gaps: hdr 16'h4108 with 8 payload words and random valid_in gaps -> record emitted after w5, the 3 extra words are consumed, the next header is parsed correctly.
- Mid-frame reset: assert rst after w3 of an add frame -> outputs and counters read 0. A fresh frame after release parses normally.
